// File: rtl/fault_pkg.sv
// Shared definitions for the fault supervisor and the channel detectors:
// supervisor state encoding and the default timing widths.
package fault_pkg;

  localparam int DLY_W_DEF      = 14;
  localparam int CLK_PER_US_DEF = 40;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_TRIPPED  = 2'd2,
    ST_CLEARING = 2'd3
  } state_t;

endpackage

// File: rtl/fault_qual_ch.sv
// One fault channel: microsecond persistence counter with saturation and
// comparison against the configured delay.
module fault_qual_ch
  import fault_pkg::*;
#(
  parameter int DLY_W = DLY_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick,
  input  logic             clr,
  input  logic             fault,
  input  logic             mask,
  input  logic [DLY_W-1:0] dly,
  output logic             qual
);

  localparam logic [DLY_W-1:0] CNT_MAX = {DLY_W{1'b1}};

  logic [DLY_W-1:0] cnt_reg;

  // Any break in the fault level restarts the persistence measurement.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (clr || mask || !fault) begin
      cnt_reg <= '0;
    end else if (tick && (cnt_reg != CNT_MAX)) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign qual = fault && !mask && (cnt_reg >= dly);

endmodule

// File: rtl/fault_supervisor.sv
// Fault supervisor: 1 us timebase, per-channel qualification, trip latching
// with first-fault capture, and the detector reset / clear handshake.
module fault_supervisor
  import fault_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int ID_W         = 2,
  parameter int DLY_W        = DLY_W_DEF,
  parameter int CLK_PER_US   = CLK_PER_US_DEF,
  parameter int UNIT_RST_CYC = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [N_CH-1:0]         fault_in,
  input  logic [N_CH-1:0]         fault_mask,
  input  logic [N_CH*DLY_W-1:0]   dly_cfg,
  input  logic                    clr_req,
  output logic                    tick_1us,
  output logic                    unit_reset,
  output logic                    trip,
  output logic [N_CH-1:0]         fault_latched,
  output logic [ID_W-1:0]         first_id,
  output logic                    first_valid,
  output logic                    clr_done,
  output logic                    clr_fail,
  output logic [1:0]              state
);

  localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;
  localparam int RW = (UNIT_RST_CYC > 1) ? $clog2(UNIT_RST_CYC) : 1;

  state_t             state_reg, state_next;
  logic [PW-1:0]      presc_reg;
  logic [RW-1:0]      rst_cnt_reg, rst_cnt_next;
  logic [N_CH-1:0]    fault_q_reg;
  logic [N_CH-1:0]    latched_reg, latched_next;
  logic [ID_W-1:0]    first_id_reg, first_id_next;
  logic               first_valid_reg, first_valid_next;
  logic               trip_reg, trip_next;
  logic               clr_done_reg, clr_done_next;
  logic               clr_fail_reg, clr_fail_next;
  logic [N_CH-1:0]    qual;
  logic               ch_clr;
  logic               clear_ok;

  function automatic logic [ID_W-1:0] lowest_idx(input logic [N_CH-1:0] v);
    logic [ID_W-1:0] r;
    r = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (v[i]) r = ID_W'(i);
    end
    return r;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_reg <= '0;
    end else if (presc_reg == PW'(CLK_PER_US - 1)) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  assign tick_1us = (presc_reg == PW'(CLK_PER_US - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault_q_reg <= '0;
    else     fault_q_reg <= fault_in;
  end

  // Counters only run while supervision is live and no detector reset is in progress.
  assign ch_clr = (state_reg == ST_IDLE) || (state_reg == ST_CLEARING);

  generate
    for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
      fault_qual_ch #(.DLY_W(DLY_W)) u_ch (
        .clk   (clk),
        .rst   (rst),
        .tick  (tick_1us),
        .clr   (ch_clr),
        .fault (fault_q_reg[gi]),
        .mask  (fault_mask[gi]),
        .dly   (dly_cfg[gi*DLY_W +: DLY_W]),
        .qual  (qual[gi])
      );
    end
  endgenerate

  assign clear_ok = ~|(fault_q_reg & ~fault_mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg       <= ST_IDLE;
      rst_cnt_reg     <= '0;
      latched_reg     <= '0;
      first_id_reg    <= '0;
      first_valid_reg <= 1'b0;
      trip_reg        <= 1'b0;
      clr_done_reg    <= 1'b0;
      clr_fail_reg    <= 1'b0;
    end else begin
      state_reg       <= state_next;
      rst_cnt_reg     <= rst_cnt_next;
      latched_reg     <= latched_next;
      first_id_reg    <= first_id_next;
      first_valid_reg <= first_valid_next;
      trip_reg        <= trip_next;
      clr_done_reg    <= clr_done_next;
      clr_fail_reg    <= clr_fail_next;
    end
  end

  always_comb begin
    state_next       = state_reg;
    rst_cnt_next     = rst_cnt_reg;
    latched_next     = latched_reg;
    first_id_next    = first_id_reg;
    first_valid_next = first_valid_reg;
    trip_next        = trip_reg;
    clr_done_next    = 1'b0;
    clr_fail_next    = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        trip_next = 1'b0;
        if (enable) state_next = ST_ARMED;
      end
      ST_ARMED: begin
        // A trip takes precedence over disarming in the same cycle.
        if (|qual) begin
          state_next       = ST_TRIPPED;
          latched_next     = latched_reg | qual;
          first_id_next    = lowest_idx(qual);
          first_valid_next = 1'b1;
          trip_next        = 1'b1;
        end else if (!enable) begin
          state_next = ST_IDLE;
        end
      end
      ST_TRIPPED: begin
        trip_next    = 1'b1;
        latched_next = latched_reg | qual;
        if (clr_req) begin
          state_next   = ST_CLEARING;
          rst_cnt_next = '0;
        end
      end
      ST_CLEARING: begin
        if (rst_cnt_reg == RW'(UNIT_RST_CYC - 1)) begin
          if (clear_ok) begin
            latched_next     = '0;
            first_id_next    = '0;
            first_valid_next = 1'b0;
            trip_next        = 1'b0;
            clr_done_next    = 1'b1;
            state_next       = enable ? ST_ARMED : ST_IDLE;
          end else begin
            clr_fail_next = 1'b1;
            state_next    = ST_TRIPPED;
          end
        end else begin
          rst_cnt_next = rst_cnt_reg + 1'b1;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  assign unit_reset    = (state_reg == ST_CLEARING);
  assign trip          = trip_reg;
  assign fault_latched = latched_reg;
  assign first_id      = first_id_reg;
  assign first_valid   = first_valid_reg;
  assign clr_done      = clr_done_reg;
  assign clr_fail      = clr_fail_reg;
  assign state         = state_reg;

endmodule

// File: tb/tb_fault_supervisor.sv
// Directed bench for fault_supervisor: timebase, qualification, latching,
// clear handshake and asynchronous reset.
module tb_fault_supervisor;

  localparam int N_CH  = 4;
  localparam int ID_W  = 2;
  localparam int DLY_W = 14;

  logic                  clk;
  logic                  rst;
  logic                  enable;
  logic [N_CH-1:0]       fault_in;
  logic [N_CH-1:0]       fault_mask;
  logic [N_CH*DLY_W-1:0] dly_cfg;
  logic                  clr_req;
  logic                  tick_1us;
  logic                  unit_reset;
  logic                  trip;
  logic [N_CH-1:0]       fault_latched;
  logic [ID_W-1:0]       first_id;
  logic                  first_valid;
  logic                  clr_done;
  logic                  clr_fail;
  logic [1:0]            state;

  int checks;
  int errors;

  fault_supervisor #(
    .N_CH(N_CH), .ID_W(ID_W), .DLY_W(DLY_W), .CLK_PER_US(40), .UNIT_RST_CYC(8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .enable        (enable),
    .fault_in      (fault_in),
    .fault_mask    (fault_mask),
    .dly_cfg       (dly_cfg),
    .clr_req       (clr_req),
    .tick_1us      (tick_1us),
    .unit_reset    (unit_reset),
    .trip          (trip),
    .fault_latched (fault_latched),
    .first_id      (first_id),
    .first_valid   (first_valid),
    .clr_done      (clr_done),
    .clr_fail      (clr_fail),
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(negedge clk);
  endtask

  task automatic set_dly(input int ch, input int val);
    dly_cfg[ch*DLY_W +: DLY_W] = DLY_W'(val);
  endtask

  // Advances at least one cycle and stops in the next cycle with tick_1us high.
  task automatic wait_tick();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (tick_1us !== 1'b1 && n < 60);
    if (tick_1us !== 1'b1) begin
      checks++;
      errors++;
      $display("FAIL wait_tick: tick_1us=%b after %0d cycles, required 1", tick_1us, n);
    end
  endtask

  task automatic pulse_clr();
    clr_req = 1'b1;
    step();
    clr_req = 1'b0;
  endtask

  // Counts cycles with unit_reset high; returns at the first cycle after it drops.
  task automatic count_unit_reset(output int n);
    n = 0;
    while (unit_reset === 1'b1 && n < 20) begin
      n++;
      step();
    end
  endtask

  task automatic test_reset();
    repeat (3) step();
    checks++;
    if ({tick_1us, unit_reset, trip, fault_latched, first_id, first_valid, clr_done, clr_fail, state} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got tick=%b ur=%b trip=%b lat=%b id=%0d fv=%b done=%b fail=%b st=%0d, required all 0",
               tick_1us, unit_reset, trip, fault_latched, first_id, first_valid, clr_done, clr_fail, state);
    end
    rst = 1'b0;
    $display("test_reset done");
  endtask

  task automatic test_prescaler();
    int bad, ticks;
    bad = 0;
    ticks = 0;
    for (int k = 0; k < 200; k++) begin
      if (tick_1us !== ((k % 40) == 39)) bad++;
      if (tick_1us === 1'b1) ticks++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL prescaler_phase: %0d cycles with wrong tick_1us, required 0", bad);
    end
    checks++;
    if (ticks != 5) begin
      errors++;
      $display("FAIL prescaler_count: %0d ticks in 200 cycles, required 5", ticks);
    end
    $display("test_prescaler done ticks=%0d", ticks);
  endtask

  task automatic test_basic_qualify();
    enable = 1'b1;
    set_dly(1, 3);
    step();
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL armed_state: state=%0d, required 1", state);
    end
    wait_tick();
    fault_in = 4'b0010;
    wait_tick();
    wait_tick();
    wait_tick();
    checks++;
    if (trip !== 1'b0) begin
      errors++;
      $display("FAIL qual_early_tick3: trip=%b, required 0", trip);
    end
    step();
    checks++;
    if (trip !== 1'b0) begin
      errors++;
      $display("FAIL qual_early_cycle: trip=%b, required 0", trip);
    end
    step();
    checks++;
    if ({trip, state, fault_latched, first_id, first_valid} !== {1'b1, 2'd2, 4'b0010, 2'd1, 1'b1}) begin
      errors++;
      $display("FAIL basic_trip: trip=%b st=%0d lat=%b id=%0d fv=%b, required 1 2 0010 1 1",
               trip, state, fault_latched, first_id, first_valid);
    end
    $display("test_basic_qualify done trip=%b lat=%b", trip, fault_latched);
  endtask

  task automatic test_clear_success();
    int n;
    fault_in = 4'b0000;
    step();
    step();
    pulse_clr();
    checks++;
    if ({unit_reset, trip, state} !== {1'b1, 1'b1, 2'd3}) begin
      errors++;
      $display("FAIL clearing_entry: ur=%b trip=%b st=%0d, required 1 1 3", unit_reset, trip, state);
    end
    count_unit_reset(n);
    checks++;
    if (n != 8) begin
      errors++;
      $display("FAIL unit_reset_len: %0d cycles, required 8", n);
    end
    checks++;
    if ({clr_done, clr_fail, trip, state, fault_latched, first_valid} !== {1'b1, 1'b0, 1'b0, 2'd1, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL clear_ok: done=%b fail=%b trip=%b st=%0d lat=%b fv=%b, required 1 0 0 1 0000 0",
               clr_done, clr_fail, trip, state, fault_latched, first_valid);
    end
    step();
    checks++;
    if (clr_done !== 1'b0) begin
      errors++;
      $display("FAIL clr_done_width: clr_done=%b, required 0", clr_done);
    end
    $display("test_clear_success done unit_reset_cycles=%0d", n);
  endtask

  task automatic test_glitch();
    set_dly(0, 5);
    wait_tick();
    fault_in = 4'b0001;
    wait_tick();
    wait_tick();
    step();
    fault_in = 4'b0000;
    repeat (3) step();
    checks++;
    if ({trip, state} !== {1'b0, 2'd1}) begin
      errors++;
      $display("FAIL glitch_no_trip: trip=%b st=%0d, required 0 1", trip, state);
    end
    // If the 2 us of the glitch were retained, 4 more ticks would reach 5.
    fault_in = 4'b0001;
    repeat (4) wait_tick();
    step();
    step();
    checks++;
    if (trip !== 1'b0) begin
      errors++;
      $display("FAIL glitch_cnt_reset: trip=%b, required 0", trip);
    end
    fault_in = 4'b0000;
    step();
    step();
    $display("test_glitch done trip=%b", trip);
  endtask

  task automatic test_simultaneous();
    set_dly(2, 0);
    set_dly(3, 0);
    fault_in = 4'b1100;
    step();
    checks++;
    if (trip !== 1'b0) begin
      errors++;
      $display("FAIL zero_dly_latency: trip=%b, required 0", trip);
    end
    step();
    checks++;
    if ({trip, state, fault_latched, first_id, first_valid} !== {1'b1, 2'd2, 4'b1100, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL simultaneous_trip: trip=%b st=%0d lat=%b id=%0d fv=%b, required 1 2 1100 2 1",
               trip, state, fault_latched, first_id, first_valid);
    end
    $display("test_simultaneous done lat=%b id=%0d", fault_latched, first_id);
  endtask

  task automatic test_clear_fail_mask();
    int n;
    pulse_clr();
    count_unit_reset(n);
    checks++;
    if ({n == 8, clr_fail, clr_done, state, fault_latched, first_id, trip} !== {1'b1, 1'b1, 1'b0, 2'd2, 4'b1100, 2'd2, 1'b1}) begin
      errors++;
      $display("FAIL clear_fail: cyc=%0d fail=%b done=%b st=%0d lat=%b id=%0d trip=%b, required 8 1 0 2 1100 2 1",
               n, clr_fail, clr_done, state, fault_latched, first_id, trip);
    end
    step();
    checks++;
    if (clr_fail !== 1'b0) begin
      errors++;
      $display("FAIL clr_fail_width: clr_fail=%b, required 0", clr_fail);
    end
    fault_mask = 4'b1100;
    step();
    checks++;
    if (fault_latched !== 4'b1100) begin
      errors++;
      $display("FAIL mask_keeps_latch: lat=%b, required 1100", fault_latched);
    end
    pulse_clr();
    count_unit_reset(n);
    checks++;
    if ({clr_done, clr_fail, state, fault_latched, trip} !== {1'b1, 1'b0, 2'd1, 4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL masked_clear: done=%b fail=%b st=%0d lat=%b trip=%b, required 1 0 1 0000 0",
               clr_done, clr_fail, state, fault_latched, trip);
    end
    repeat (3) step();
    checks++;
    if (trip !== 1'b0) begin
      errors++;
      $display("FAIL masked_no_trip: trip=%b, required 0", trip);
    end
    $display("test_clear_fail_mask done st=%0d", state);
  endtask

  task automatic test_async_reset();
    fault_mask = 4'b1000;
    step();
    step();
    checks++;
    if ({trip, fault_latched, first_id} !== {1'b1, 4'b0100, 2'd2}) begin
      errors++;
      $display("FAIL unmask_trip: trip=%b lat=%b id=%0d, required 1 0100 2", trip, fault_latched, first_id);
    end
    fault_in = 4'b0000;
    step();
    step();
    pulse_clr();
    repeat (3) step();
    checks++;
    if (unit_reset !== 1'b1) begin
      errors++;
      $display("FAIL mid_clear: unit_reset=%b, required 1", unit_reset);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if ({tick_1us, unit_reset, trip, fault_latched, first_id, first_valid, clr_done, clr_fail, state} !== '0) begin
      errors++;
      $display("FAIL async_reset: tick=%b ur=%b trip=%b lat=%b id=%0d fv=%b done=%b fail=%b st=%0d, required all 0",
               tick_1us, unit_reset, trip, fault_latched, first_id, first_valid, clr_done, clr_fail, state);
    end
    step();
    rst = 1'b0;
    $display("test_async_reset done");
  endtask

  task automatic test_ignore_and_priority();
    int bad;
    step();
    checks++;
    if (state !== 2'd1) begin
      errors++;
      $display("FAIL rearm: state=%0d, required 1", state);
    end
    pulse_clr();
    bad = 0;
    for (int k = 0; k < 12; k++) begin
      if (clr_done !== 1'b0 || clr_fail !== 1'b0 || unit_reset !== 1'b0 || state !== 2'd1) bad++;
      step();
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL clr_in_armed: %0d cycles with activity, required 0", bad);
    end
    fault_in = 4'b0100;
    step();
    enable = 1'b0;
    step();
    checks++;
    if ({trip, state, first_id} !== {1'b1, 2'd2, 2'd2}) begin
      errors++;
      $display("FAIL trip_beats_disable: trip=%b st=%0d id=%0d, required 1 2 2", trip, state, first_id);
    end
    $display("test_ignore_and_priority done st=%0d", state);
  endtask

  initial begin
    checks     = 0;
    errors     = 0;
    rst        = 1'b1;
    enable     = 1'b0;
    fault_in   = '0;
    fault_mask = '0;
    clr_req    = 1'b0;
    for (int i = 0; i < N_CH; i++) set_dly(i, 1000);
    test_reset();
    test_prescaler();
    test_basic_qualify();
    test_clear_success();
    test_glitch();
    test_simultaneous();
    test_clear_fail_mask();
    test_async_reset();
    test_ignore_and_priority();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/fault_supervisor.md
Name: fault_supervisor

Overview:
- Central controller for the per-channel high-level fault detectors on the test board.
- Generates the shared 1 us timebase and qualifies each debounced fault against a per-channel delay in microseconds.
- Latches trips and records the first faulting channel.
- Sequences the detector reset pulse (unit_reset) through a clear handshake with the host logic.

Parameters:
- N_CH, 4: number of fault channels.
- ID_W, 2: width of the channel index; must satisfy 2^ID_W >= N_CH.
- DLY_W, 14: width of each delay threshold and counter, in microseconds.
- CLK_PER_US, 40: clk cycles per 1 us tick.
- UNIT_RST_CYC, 8: number of cycles unit_reset is held during a clear.

Ports:
- clk, in, 1: system clock.
- rst, in, 1: asynchronous, active-high reset.
- enable, in, 1: arms supervision.
- fault_in, in, N_CH: debounced, active-high fault levels from the detectors.
- fault_mask, in, N_CH: 1 = channel ignored.
- dly_cfg, in, N_CH*DLY_W: per-channel threshold in us; channel i occupies bits [i*DLY_W +: DLY_W].
- clr_req, in, 1: single-cycle clear request.
- tick_1us, out, 1: one-cycle pulse every CLK_PER_US cycles.
- unit_reset, out, 1: reset strobe to the detectors.
- trip, out, 1: global trip output.
- fault_latched, out, N_CH: sticky per-channel trip flags.
- first_id, out, ID_W: index of the first tripped channel.
- first_valid, out, 1: first_id is valid.
- clr_done, out, 1: one-cycle pulse when a clear succeeds.
- clr_fail, out, 1: one-cycle pulse when a clear fails.
- state, out, 2: IDLE=0, ARMED=1, TRIPPED=2, CLEARING=3.

Behaviour:
- Reset: all outputs 0, state IDLE, prescaler 0, all counters 0.
- Prescaler: free-running from 0 to CLK_PER_US-1. tick_1us is high in the cycle the count equals CLK_PER_US-1. It runs in every state.
- Input stage: fault_in is registered once into fault_q. All qualification uses fault_q, giving 1 cycle of input latency.
- Per-channel counter cnt[i]:
  - cleared when masked, when fault_q[i]=0, in IDLE, or in CLEARING;
  - otherwise incremented on tick_1us, saturating at 2^DLY_W-1.
- Qualification: qual[i] = fault_q[i] & ~fault_mask[i] & (cnt[i] >= dly_cfg[i]).
  - With dly_cfg=0, a channel qualifies in the first cycle fault_q is high.
  - Comparison is unsigned and DLY_W bits wide.
- IDLE:
  - trip=0; latches are preserved.
  - enable=1 moves to ARMED next cycle.
- ARMED:
  - enable=0 returns to IDLE.
  - Any qual moves to TRIPPED. In that cycle, fault_latched |= qual, first_id = lowest set index of qual, first_valid=1.
  - trip goes high on the following clock edge, so it is registered in the same edge as the state change.
  - If qual and enable=0 occur together, the trip wins.
- TRIPPED:
  - trip=1.
  - New qual bits are OR-ed into fault_latched; first_id stays frozen.
  - enable is ignored.
  - clr_req moves to CLEARING. A qual in the same cycle is still latched.
- CLEARING:
  - unit_reset=1 for exactly UNIT_RST_CYC cycles; counters are held at 0 and trip stays 1.
  - After the last reset cycle the block evaluates clear_ok = no unmasked fault_q bit set.
  - clear_ok=1: fault_latched, first_valid, first_id and trip are cleared. clr_done pulses. Next state is ARMED if enable=1, otherwise IDLE.
  - clear_ok=0: clr_fail pulses, latches are kept, and the state returns to TRIPPED.
  - clr_req during CLEARING is ignored.
- clr_req in IDLE or ARMED is ignored, with no pulse on either status output.
- An asynchronous rst at any point, including mid-CLEARING, forces full reset in the same instant; unit_reset drops immediately.
- A mask change takes effect on the next cycle. Masking a channel does not clear its latched bit.

Decomposition:
- Shared package fault_pkg holds:
  - the state encoding constants (ST_IDLE, ST_ARMED, ST_TRIPPED, ST_CLEARING);
  - the defaults for DLY_W and CLK_PER_US, which the detectors also use.
- One natural sub-module: fault_qual_ch, instantiated N_CH times.
  - Contains the counter, saturation and comparator.
  - Inputs: clk, rst, tick, clr, fault, mask, dly. Output: qual.
- Prescaler, FSM, latching and priority encoder live in the top.

Test Plan:
- Prescaler: CLK_PER_US=40, run 200 cycles after reset -> tick_1us pulses at cycles 39, 79, 119, 159, 199, each 1 cycle wide.
- Basic qualify: enable=1, dly_cfg[1]=3, fault_in[1] held high -> trip rises after the 3rd tick following fault_q high. fault_latched=0010, first_id=1.
- Glitch rejection and simultaneous trip:
  - dly_cfg[0]=5, fault_in[0] high for 2 us then low -> no trip, cnt[0] back to 0.
  - Channels 2 and 3 with dly_cfg=0 rising together -> first_id=2, fault_latched=1100.
- Clear success: after trip, fault_in=0, pulse clr_req -> unit_reset high for 8 cycles. Then clr_done pulses, trip=0, state=ARMED.
- Clear failure and masking:
  - Fault held high during clear -> clr_fail pulses, state=TRIPPED, latches unchanged.
  - Set fault_mask for that channel and repeat the clear -> clr_done.
- Async reset mid-CLEARING at cycle 4 of unit_reset -> all outputs 0 immediately, state=IDLE. Ignore case: clr_req in ARMED -> no clr_done and no clr_fail pulse.
